aes_encrypt_iter: RTL
=====================

AES_ENCRYPT_ITER -- requirements
Module: aes_encrypt_iter

Interface
REQ-001 Parameters: none; round count is selected at run time by klen_sel.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 pt  in  [0:127]  plaintext block; bit 0 is the MSB of byte 0; bytes are column-major per FIPS-197.
REQ-005 pt_vld  in  1  plaintext valid.
REQ-006 pt_rdy  out  1  encryptor ready to accept plaintext.
REQ-007 rkey  in  [0:127]  round key stream, forward order key0..keyNr, from the KschBuffer output side.
REQ-008 rkey_vld  in  1  rkey is valid.
REQ-009 next_rkey  out  1  one-cycle pulse: the current rkey was consumed, so advance the stream.
REQ-010 klen_sel  in  [1:0]  key length: 00 selects 128 (Nr=10), 01 selects 192 (Nr=12), 10 selects 256 (Nr=14), 11 is treated as 128.
REQ-011 ct  out  [0:127]  ciphertext, in the same byte order as pt.
REQ-012 ct_vld  out  1  one-cycle pulse: ct holds a new ciphertext.

Function
REQ-013 FSM states are IDLE, ARK0, ROUND and DONE.
REQ-014 IDLE: pt_rdy=1. When pt_vld=1, capture pt and klen_sel and go to ARK0.
REQ-015 pt_rdy SHALL be 0 in every state other than IDLE and DONE.
REQ-016 ARK0: when rkey_vld=1, compute state = pt ^ rkey, pulse next_rkey, set round counter to 1 and go to ROUND.
REQ-017 ROUND, when rkey_vld=1 and the counter is below Nr: compute state = MixColumns(ShiftRows(SubBytes(state))) ^ rkey, pulse next_rkey and increment the counter.
REQ-018 ROUND, when rkey_vld=1 and the counter equals Nr: omit MixColumns, load ct, pulse next_rkey and go to DONE.
REQ-019 rkey_vld=0 in ARK0 or ROUND stalls the core: state, counter and FSM hold, and next_rkey stays 0.
REQ-020 DONE lasts one cycle: ct_vld=1 and pt_rdy=1.
REQ-021 In DONE, pt_vld=1 captures a new block and goes to ARK0 (back-to-back operation); otherwise go to IDLE.
REQ-022 Latency with rkey_vld held high: acceptance at cycle T gives ct_vld at T+Nr+2, which is 12 cycles for AES-128.
REQ-023 Sustained throughput is one block every Nr+2 cycles.
REQ-024 next_rkey SHALL pulse exactly Nr+1 times per block and never outside ARK0/ROUND.
REQ-025 ct SHALL hold its value from one ct_vld to the next.
REQ-026 Changes to pt or klen_sel after acceptance SHALL NOT affect the block in flight.
REQ-027 The captured Nr is fixed for the whole block.

Reset
REQ-028 On rst=1 the FSM goes to IDLE, the counter to 0, and the state register and ct to 128'h0.
REQ-029 Reset values of outputs: pt_rdy=1 (from the first cycle after reset), next_rkey=0, ct_vld=0.
REQ-030 rst asserted mid-block aborts the block with no ct_vld. Resynchronising the key stream is the responsibility of the KschBuffer, which shares rst.
REQ-031 rst has priority over pt_vld and rkey_vld in the same cycle.

Structure
REQ-032 Package aes_enc_pkg SHALL hold the FSM state enum, the KLEN_128/192/256 encodings, the NR_128/192/256 constants (10/12/14) and a function mapping klen_sel to Nr.
REQ-033 One sub-module, aes_enc_round, SHALL perform SubBytes (16 instances of the existing Sbox), ShiftRows, MixColumns (xtime-based) and AddRoundKey.
REQ-034 aes_enc_round SHALL have a last_round input that bypasses MixColumns.
REQ-035 aes_enc_round SHALL be purely combinational; the only registers are in aes_encrypt_iter.
REQ-036 The KeyExpand128 and KschBuffer pairing SHALL connect unchanged, with klen_sel=2'b00 for the 128-bit wrapper.

Verification
REQ-037 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32, with ct_vld at acceptance+12.
REQ-038 FIPS-197 C.1: key 000102..0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a, and exactly 11 next_rkey pulses.
REQ-039 C.2 with klen_sel=01, key 000102..17 -> ct dda97ca4864cdfe06eaf70a0ec0d7191 at +14. C.3 with klen_sel=10, key 000102..1f -> ct 8ea2b7ca516745bfeafc49904b496089 at +16.
REQ-040 Random rkey_vld deassertion during the C.1 run -> same ct; ct_vld delayed by exactly the number of stall cycles; no next_rkey pulse while rkey_vld=0.
REQ-041 Back-to-back: pt_vld held high for 3 C.1 blocks -> 3 ct_vld pulses 12 cycles apart, all with the correct ct.
REQ-042 rst pulse during round 5 -> no ct_vld, pt_rdy=1 the next cycle; a following full C.1 run gives the correct ct.

Source files
------------

// File: rtl/aes_enc_pkg.sv
// Shared types and constants for the iterative AES encryptor.
// Provides the FSM state enum, key-length encodings, round counts and GF(2^8) helpers.
package aes_enc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ARK0  = 2'b01,
      ST_ROUND = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   localparam logic [1:0] KLEN_128 = 2'b00;
   localparam logic [1:0] KLEN_192 = 2'b01;
   localparam logic [1:0] KLEN_256 = 2'b10;

   localparam logic [3:0] NR_128 = 4'd10;
   localparam logic [3:0] NR_192 = 4'd12;
   localparam logic [3:0] NR_256 = 4'd14;

   // The unused encoding 2'b11 falls back to AES-128.
   function automatic logic [3:0] klen_to_nr(input logic [1:0] klen);
      case (klen)
         KLEN_192: return NR_192;
         KLEN_256: return NR_256;
         default:  return NR_128;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One AES encryption round: SubBytes, ShiftRows, MixColumns (skipped on the last round), AddRoundKey.
// Purely combinational; byte k of the block is row k%4, column k/4.
module aes_enc_round
   import aes_enc_pkg::*;
(
   input  logic [0:127] i_state,
   input  logic [0:127] i_rkey,
   input  logic         i_last_round,
   output logic [0:127] o_state
);

   logic [7:0]   w_sb [16];
   logic [7:0]   w_sr [16];
   logic [7:0]   w_mc [16];
   logic [0:127] w_mix;

   for (genvar k = 0; k < 16; k++) begin : g_sbox
      aes_sbox u_sbox (
         .i_in  (i_state[8*k +: 8]),
         .o_out (w_sb[k])
      );
   end

   for (genvar c = 0; c < 4; c++) begin : g_col
      // Row r rotates left by r columns.
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign w_sr[4*c+r] = w_sb[4*((c+r)%4)+r];
      end

      assign w_mc[4*c+0] = xtime(w_sr[4*c+0]) ^ xtime(w_sr[4*c+1]) ^ w_sr[4*c+1]
                         ^ w_sr[4*c+2] ^ w_sr[4*c+3];
      assign w_mc[4*c+1] = w_sr[4*c+0] ^ xtime(w_sr[4*c+1]) ^ xtime(w_sr[4*c+2])
                         ^ w_sr[4*c+2] ^ w_sr[4*c+3];
      assign w_mc[4*c+2] = w_sr[4*c+0] ^ w_sr[4*c+1] ^ xtime(w_sr[4*c+2])
                         ^ xtime(w_sr[4*c+3]) ^ w_sr[4*c+3];
      assign w_mc[4*c+3] = xtime(w_sr[4*c+0]) ^ w_sr[4*c+0] ^ w_sr[4*c+1]
                         ^ w_sr[4*c+2] ^ xtime(w_sr[4*c+3]);
   end

   for (genvar k = 0; k < 16; k++) begin : g_sel
      assign w_mix[8*k +: 8] = i_last_round ? w_sr[k] : w_mc[k];
   end

   assign o_state = w_mix ^ i_rkey;

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box, a 256-entry lookup.
// Purely combinational.
module aes_sbox (
   input  logic [7:0] i_in,
   output logic [7:0] o_out
);

   localparam logic [0:2047] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign o_out = SBOX_TBL[{i_in, 3'b000} +: 8];

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128/192/256 encryptor, one round per cycle; ct_vld Nr+2 cycles after acceptance.
// rkey_vld low stalls the datapath; next_rkey qualifies each consumed round key in the same cycle.
module aes_encrypt_iter
   import aes_enc_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [0:127] pt,
   input  logic         pt_vld,
   output logic         pt_rdy,
   input  logic [0:127] rkey,
   input  logic         rkey_vld,
   output logic         next_rkey,
   input  logic [1:0]   klen_sel,
   output logic [0:127] ct,
   output logic         ct_vld
);

   state_t       r_fsm;
   logic [3:0]   r_cnt;
   logic [3:0]   r_nr;
   logic [0:127] r_state;
   logic [0:127] r_ct;
   logic         r_pt_rdy;
   logic         r_ct_vld;

   logic [0:127] w_round;
   logic         w_last;
   logic         w_advance;

   assign w_last    = (r_cnt == r_nr);
   assign w_advance = rkey_vld && ((r_fsm == ST_ARK0) || (r_fsm == ST_ROUND));

   aes_enc_round u_round (
      .i_state      (r_state),
      .i_rkey       (rkey),
      .i_last_round (w_last),
      .o_state      (w_round)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fsm    <= ST_IDLE;
         r_cnt    <= 4'd0;
         r_nr     <= NR_128;
         r_state  <= 128'h0;
         r_ct     <= 128'h0;
         r_pt_rdy <= 1'b1;
         r_ct_vld <= 1'b0;
      end else begin
         r_ct_vld <= 1'b0;
         case (r_fsm)
            // Plaintext is captured straight into the state register; ARK0 whitens it.
            ST_IDLE, ST_DONE: begin
               if (pt_vld) begin
                  r_state  <= pt;
                  r_nr     <= klen_to_nr(klen_sel);
                  r_fsm    <= ST_ARK0;
                  r_pt_rdy <= 1'b0;
               end else begin
                  r_fsm    <= ST_IDLE;
                  r_pt_rdy <= 1'b1;
               end
            end
            ST_ARK0: begin
               if (rkey_vld) begin
                  r_state <= r_state ^ rkey;
                  r_cnt   <= 4'd1;
                  r_fsm   <= ST_ROUND;
               end
            end
            ST_ROUND: begin
               if (rkey_vld) begin
                  if (w_last) begin
                     r_ct     <= w_round;
                     r_fsm    <= ST_DONE;
                     r_ct_vld <= 1'b1;
                     r_pt_rdy <= 1'b1;
                  end else begin
                     r_state <= w_round;
                     r_cnt   <= r_cnt + 4'd1;
                  end
               end
            end
            default: begin
               r_fsm    <= ST_IDLE;
               r_pt_rdy <= 1'b1;
            end
         endcase
      end
   end

   assign pt_rdy    = r_pt_rdy;
   assign ct_vld    = r_ct_vld;
   assign ct        = r_ct;
   assign next_rkey = w_advance;

endmodule
